reservation_alu3_issue_ctrl: RTL and testbench
==============================================

# reservation_alu3_issue_ctrl

Controls a bank of four ALU3 reservation-station entries.
- Allocates a free entry for each dispatched instruction.
- Tracks the relative age of live entries with an age matrix.
- Picks the oldest entry whose operands and execution-pointer match are satisfied, and issues it to the ALU3 execution stage.
- Broadcasts flush to all entries.

It sits between dispatch and the per-entry station instances, driving their register, exout and remove strobes.

## Interface
- ENTRY_N, 4, number of entries; index width ENTRY_W = 2.
- iCLOCK  in  1  clock, rising edge.
- inRESET  in  1  reset: asynchronous, active-low.
- iFLUSH  in  1  pipeline flush; removes all entries.
- iREGIST_REQ  in  1  dispatch wants to allocate one entry.
- oREGIST_FULL  out  1  no free entry this cycle; iREGIST_REQ must not be asserted while high.
- oENTRY_REGIST  out  ENTRY_N  one-hot register strobe to entries.
- iENTRY_VALID  in  ENTRY_N  oINFO_ENTRY_VALID of each entry; consistency check only.
- iENTRY_MATCHING  in  ENTRY_N  oINFO_MATCHING of each entry.
- iEXE_BUSY  in  1  execution stage cannot accept this cycle.
- oENTRY_EXOUT  out  ENTRY_N  one-hot issue strobe, to each entry's iEXOUT_VALID.
- oENTRY_REMOVE  out  1  broadcast remove, to every entry's iREMOVE_VALID.
- oEXE_VALID  out  1  issue valid to execution stage.
- oEXE_SEL  out  ENTRY_W  index of issued entry; selects entry info mux.
- oFREE_COUNT  out  3  number of free entries (0..4).
- oERROR  out  1  sticky: internal busy bit differs from iENTRY_VALID for one full cycle after settling.

## Operation
- State: busy[ENTRY_N], age[i][j] (1 = entry i older than j, i≠j), error flag. Reset: all zero.
- Free vector = ~busy. Allocation picks the lowest-index free entry. Entries being issued this cycle are still busy and cannot be reallocated in the same cycle.
- Allocation of entry k (iREGIST_REQ & !oREGIST_FULL & !iFLUSH):
  - oENTRY_REGIST[k]=1.
  - Next cycle: busy[k]=1; age[j][k]=busy[j] for every j (all existing entries are older than k); age[k][j]=0.
- Ready vector r = busy & iENTRY_MATCHING.
- Grant: entry i wins if r[i] and no j with r[j] & age[j][i]. At most one winner.
- Issue when winner exists, !iEXE_BUSY, !iFLUSH:
  - oENTRY_EXOUT one-hot, oEXE_VALID=1, oEXE_SEL=winner; all combinational.
  - Next cycle: busy[winner]=0; row and column of winner cleared.
- Allocate and issue in the same cycle are legal and independent. A newly allocated entry is never ready in its allocation cycle.
- Flush:
  - oENTRY_REMOVE=1 combinationally.
  - No regist or exout strobes that cycle.
  - Next cycle: busy=0 and age=0.
  - iREGIST_REQ during flush is dropped; dispatch must re-issue it.
- oFREE_COUNT = popcount(~busy). oREGIST_FULL = &busy.
- oERROR: set when busy != iENTRY_VALID on a cycle whose previous cycle had no regist/exout/remove strobe. Cleared only by reset.
- Outputs at reset: all strobes 0, oEXE_VALID 0, oEXE_SEL 0, oREGIST_FULL 0, oFREE_COUNT 4, oERROR 0.

## Timing
- Allocation: strobe in cycle N; entry valid at N+1; earliest matching at N+1, since the entry resolves CDB sources at registration. Earliest issue is therefore N+1.
- Issue strobe to entry clear: 1 cycle. The entry is reallocatable at N+1.
- iEXE_BUSY stalls issue with no state change; grant is recomputed every cycle.
- Reset mid-operation: asynchronous clear of all state. Outputs take reset values immediately.

## Structure
- Shared package (core.h):
  - RS_ALU3_ENTRY_N and index width.
  - Age-matrix bit helpers as macros.
- One natural sub-module: reservation_alu3_age_select. It is combinational and takes the ready vector and age matrix, returning the one-hot grant and encoded index. It is reusable by the other station controllers.
- Popcount and lowest-free encoder stay inline.

## Test plan
- Reset, then 4 allocations in consecutive cycles -> regist strobes 0001, 0010, 0100, 1000; oREGIST_FULL=1 at cycle 4; oFREE_COUNT 4→0.
- Allocate entries 0, 1, 2 in that order; assert matching on 2 then 1 in the same cycle -> issue entry 1 (oldest ready), oEXE_SEL=1, then entry 2 the next cycle.
- Full bank: issue entry 0 while iREGIST_REQ is asserted -> no allocation that cycle. Next cycle, entry 0 is reallocated and is the youngest: later simultaneous ready on 0 and 3 issues 3 first.
- iEXE_BUSY=1 with entries 1 and 3 ready -> no oEXE_VALID. Release -> the older of 1 and 3 issues; busy unchanged during the stall.
- iFLUSH with 3 busy entries and a pending regist request -> oENTRY_REMOVE=1, no strobes; next cycle oFREE_COUNT=4 and age cleared.
- Hold iENTRY_VALID[2]=0 while busy[2]=1 for two idle cycles -> oERROR=1, sticky until inRESET low.

Source files
------------

// File: rtl/reservation_alu3_issue_ctrl_pkg.sv
// Shared definitions for the ALU3 reservation-station controllers:
// entry count, index width, age-matrix type and its bit helper.
package reservation_alu3_issue_ctrl_pkg;

  localparam int RS_ALU3_ENTRY_N = 4;
  localparam int RS_ALU3_ENTRY_W = 2;

  // age[i][j] = 1 means entry i is older than entry j
  typedef logic [RS_ALU3_ENTRY_N-1:0][RS_ALU3_ENTRY_N-1:0] age_mtx_t;

  // Issue response towards the execution stage
  typedef struct packed {
    logic                       vld;
    logic [RS_ALU3_ENTRY_W-1:0] sel;
    logic [RS_ALU3_ENTRY_N-1:0] onehot;
  } issue_rsp_t;

  function automatic logic age_older(input age_mtx_t m, input int i, input int j);
    return m[i][j];
  endfunction

endpackage

// File: rtl/reservation_alu3_issue_ctrl_age_select.sv
// Oldest-ready picker: an entry wins when it is ready and no other ready
// entry is older. Purely combinational, shared by the station controllers.
module reservation_alu3_age_select
  import reservation_alu3_issue_ctrl_pkg::*;
#(
  parameter int NUM_LANES = RS_ALU3_ENTRY_N,
  parameter int IDX_W     = RS_ALU3_ENTRY_W
) (
  input  logic [NUM_LANES-1:0]                ready,
  input  logic [NUM_LANES-1:0][NUM_LANES-1:0] age,
  output logic [NUM_LANES-1:0]                grant,
  output logic [IDX_W-1:0]                    idx,
  output logic                                any
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [NUM_LANES-1:0] older;
    for (genvar j = 0; j < NUM_LANES; j++) begin : g_col
      assign older[j] = age[j][i];
    end
    assign grant[i] = ready[i] & ~|(ready & older);
  end

  assign any = |grant;

  // Encode the (at most one-hot) grant into an index
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (grant[i]) idx = IDX_W'(i);
  end

endmodule

// File: rtl/reservation_alu3_issue_ctrl.sv
// ALU3 reservation-station controller: allocates entries for dispatch,
// keeps an age matrix, issues the oldest ready entry and handles flush.
module reservation_alu3_issue_ctrl
  import reservation_alu3_issue_ctrl_pkg::*;
(
  input  logic                       iCLOCK,
  input  logic                       inRESET,
  input  logic                       iFLUSH,
  input  logic                       iREGIST_REQ,
  output logic                       oREGIST_FULL,
  output logic [RS_ALU3_ENTRY_N-1:0] oENTRY_REGIST,
  input  logic [RS_ALU3_ENTRY_N-1:0] iENTRY_VALID,
  input  logic [RS_ALU3_ENTRY_N-1:0] iENTRY_MATCHING,
  input  logic                       iEXE_BUSY,
  output logic [RS_ALU3_ENTRY_N-1:0] oENTRY_EXOUT,
  output logic                       oENTRY_REMOVE,
  output logic                       oEXE_VALID,
  output logic [RS_ALU3_ENTRY_W-1:0] oEXE_SEL,
  output logic [2:0]                 oFREE_COUNT,
  output logic                       oERROR
);

  localparam int N = RS_ALU3_ENTRY_N;
  localparam int W = RS_ALU3_ENTRY_W;

  logic [N-1:0] busy, busy_n, free, alloc_oh, ready, grant;
  age_mtx_t     age, age_n;
  logic [W-1:0] grant_idx;
  logic         grant_any, do_alloc, found, error, error_n, prev_strobe;
  issue_rsp_t   issue;
  logic [2:0]   free_cnt;

  assign free         = ~busy;
  assign oREGIST_FULL = &busy;
  assign ready        = busy & iENTRY_MATCHING;

  // Lowest-index free entry; entries issuing this cycle still count as busy
  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++)
      if (free[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
  end

  reservation_alu3_age_select #(.NUM_LANES(N), .IDX_W(W)) u_sel (
    .ready (ready),
    .age   (age),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign do_alloc      = iREGIST_REQ & ~oREGIST_FULL & ~iFLUSH;
  assign issue.vld     = grant_any & ~iEXE_BUSY & ~iFLUSH;
  assign issue.sel     = issue.vld ? grant_idx : '0;
  assign issue.onehot  = issue.vld ? grant : '0;

  assign oENTRY_REGIST = do_alloc ? alloc_oh : '0;
  assign oENTRY_EXOUT  = issue.onehot;
  assign oEXE_VALID    = issue.vld;
  assign oEXE_SEL      = issue.sel;
  assign oENTRY_REMOVE = iFLUSH;

  // Free-entry popcount
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < N; i++) free_cnt = free_cnt + 3'(free[i]);
  end
  assign oFREE_COUNT = free_cnt;

  // Next busy/age state; allocation is applied first so that an entry
  // issued in the same cycle ends with a fully cleared row and column
  always_comb begin
    busy_n = busy;
    age_n  = age;
    if (iFLUSH) begin
      busy_n = '0;
      age_n  = '0;
    end else begin
      for (int k = 0; k < N; k++)
        if (oENTRY_REGIST[k]) begin
          busy_n[k] = 1'b1;
          for (int j = 0; j < N; j++) begin
            age_n[j][k] = busy[j];
            age_n[k][j] = 1'b0;
          end
        end
      for (int w = 0; w < N; w++)
        if (oENTRY_EXOUT[w]) begin
          busy_n[w] = 1'b0;
          for (int j = 0; j < N; j++) begin
            age_n[w][j] = 1'b0;
            age_n[j][w] = 1'b0;
          end
        end
    end
  end

  // Busy mirror is only compared once a strobe-free cycle has let entries settle
  assign error_n = error | (~prev_strobe & (busy != iENTRY_VALID));
  assign oERROR  = error;

  // State registers
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      busy        <= '0;
      age         <= '0;
      error       <= 1'b0;
      prev_strobe <= 1'b0;
    end else begin
      busy        <= busy_n;
      age         <= age_n;
      error       <= error_n;
      prev_strobe <= (|oENTRY_REGIST) | (|oENTRY_EXOUT) | oENTRY_REMOVE;
    end
  end

endmodule

// File: tb/tb_reservation_alu3_issue_ctrl.sv
// Directed bench for the ALU3 issue controller; issues are checked against a
// queue of expected entry indices filled when matching stimulus is driven.
module tb_reservation_alu3_issue_ctrl;

  logic       iCLOCK = 1'b0;
  logic       inRESET, iFLUSH, iREGIST_REQ, iEXE_BUSY;
  logic [3:0] iENTRY_VALID, iENTRY_MATCHING;
  logic       oREGIST_FULL, oENTRY_REMOVE, oEXE_VALID, oERROR;
  logic [3:0] oENTRY_REGIST, oENTRY_EXOUT;
  logic [1:0] oEXE_SEL;
  logic [2:0] oFREE_COUNT;

  logic [3:0] vm;          // emulated per-entry valid flops
  logic [3:0] kill;        // forces entry valid low to provoke the error check
  int         n_tests = 0;
  int         n_fail  = 0;
  int         sb[$];

  reservation_alu3_issue_ctrl dut (
    .iCLOCK          (iCLOCK),
    .inRESET         (inRESET),
    .iFLUSH          (iFLUSH),
    .iREGIST_REQ     (iREGIST_REQ),
    .oREGIST_FULL    (oREGIST_FULL),
    .oENTRY_REGIST   (oENTRY_REGIST),
    .iENTRY_VALID    (iENTRY_VALID),
    .iENTRY_MATCHING (iENTRY_MATCHING),
    .iEXE_BUSY       (iEXE_BUSY),
    .oENTRY_EXOUT    (oENTRY_EXOUT),
    .oENTRY_REMOVE   (oENTRY_REMOVE),
    .oEXE_VALID      (oEXE_VALID),
    .oEXE_SEL        (oEXE_SEL),
    .oFREE_COUNT     (oFREE_COUNT),
    .oERROR          (oERROR)
  );

  always #5 iCLOCK = ~iCLOCK;

  assign iENTRY_VALID = vm & ~kill;

  // Entry valid flops respond to the controller strobes like real stations
  always @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)          vm <= '0;
    else if (oENTRY_REMOVE) vm <= '0;
    else                   vm <= (vm | oENTRY_REGIST) & ~oENTRY_EXOUT;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #2;
  endtask

  // Scoreboard: every issue must match the next expected entry index
  always @(negedge iCLOCK) begin
    if (inRESET && oEXE_VALID) begin
      if (sb.size() == 0) chk("sb_unexpected_sel", int'(oEXE_SEL), -1);
      else begin
        automatic int e = sb.pop_front();
        chk("sb_issue_sel", int'(oEXE_SEL), e);
        chk("sb_issue_exout", int'(oENTRY_EXOUT), 1 << e);
      end
    end
  end

  initial begin
    inRESET = 1'b0; iFLUSH = 1'b0; iREGIST_REQ = 1'b0; iEXE_BUSY = 1'b0;
    iENTRY_MATCHING = '0; kill = '0;
    #3;
    chk("rst_regist", oENTRY_REGIST, 0);
    chk("rst_exout", oENTRY_EXOUT, 0);
    chk("rst_exe_valid", oEXE_VALID, 0);
    chk("rst_sel", oEXE_SEL, 0);
    chk("rst_full", oREGIST_FULL, 0);
    chk("rst_free", oFREE_COUNT, 4);
    chk("rst_err", oERROR, 0);
    #10 inRESET = 1'b1;
    tick();

    // fill the bank in consecutive cycles
    for (int k = 0; k < 4; k++) begin
      iREGIST_REQ = 1'b1;
      #1;
      chk("fill_regist", oENTRY_REGIST, 1 << k);
      chk("fill_full", oREGIST_FULL, 0);
      chk("fill_free", oFREE_COUNT, 4 - k);
      tick();
    end
    iREGIST_REQ = 1'b0;
    #1;
    chk("full_flag", oREGIST_FULL, 1);
    chk("full_free", oFREE_COUNT, 0);

    // issue 0 while full with a pending request: no allocation this cycle
    iREGIST_REQ = 1'b1; iENTRY_MATCHING = 4'b0001; sb.push_back(0);
    #1;
    chk("full_no_alloc", oENTRY_REGIST, 0);
    tick();
    iENTRY_MATCHING = '0;
    #1;
    chk("realloc0", oENTRY_REGIST, 4'b0001);
    tick();
    // entry 0 is now youngest: 3 goes before 0
    iREGIST_REQ = 1'b0; iENTRY_MATCHING = 4'b1001;
    sb.push_back(3); sb.push_back(0);
    tick(); tick();
    iENTRY_MATCHING = '0;
    tick();

    // refill entries 0 and 3, then stall issue with 1 and 3 ready
    iREGIST_REQ = 1'b1;
    #1 chk("refill0", oENTRY_REGIST, 4'b0001);
    tick();
    #1 chk("refill3", oENTRY_REGIST, 4'b1000);
    tick();
    iREGIST_REQ = 1'b0; iEXE_BUSY = 1'b1; iENTRY_MATCHING = 4'b1010;
    #1;
    chk("stall_valid", oEXE_VALID, 0);
    chk("stall_exout", oENTRY_EXOUT, 0);
    tick();
    #1;
    chk("stall_valid2", oEXE_VALID, 0);
    chk("stall_free", oFREE_COUNT, 0);
    iEXE_BUSY = 1'b0; sb.push_back(1); sb.push_back(3);
    tick(); tick();
    iENTRY_MATCHING = '0;

    // flush with three busy entries and a pending request
    iREGIST_REQ = 1'b1;
    #1 chk("pre_flush_regist", oENTRY_REGIST, 4'b0010);
    tick();
    iFLUSH = 1'b1; iENTRY_MATCHING = 4'b0111;
    #1;
    chk("flush_remove", oENTRY_REMOVE, 1);
    chk("flush_regist", oENTRY_REGIST, 0);
    chk("flush_exout", oENTRY_EXOUT, 0);
    chk("flush_valid", oEXE_VALID, 0);
    tick();
    iFLUSH = 1'b0; iREGIST_REQ = 1'b0; iENTRY_MATCHING = '0;
    #1;
    chk("post_flush_free", oFREE_COUNT, 4);
    chk("post_flush_full", oREGIST_FULL, 0);
    chk("post_flush_remove", oENTRY_REMOVE, 0);
    iREGIST_REQ = 1'b1;
    tick(); tick();
    iREGIST_REQ = 1'b0; iENTRY_MATCHING = 4'b0011;
    sb.push_back(0); sb.push_back(1);
    tick(); tick();
    iENTRY_MATCHING = '0;

    // allocate 0,1,2; ready on 2 and 1 together: 1 first
    for (int k = 0; k < 3; k++) begin
      iREGIST_REQ = 1'b1;
      #1 chk("alloc012", oENTRY_REGIST, 1 << k);
      tick();
    end
    iREGIST_REQ = 1'b0; iENTRY_MATCHING = 4'b0110;
    sb.push_back(1); sb.push_back(2);
    #1 chk("oldest_sel", oEXE_SEL, 1);
    tick(); tick();
    iENTRY_MATCHING = '0;

    // entry 2 valid dropped while busy: sticky error
    iREGIST_REQ = 1'b1;
    tick(); tick();
    iREGIST_REQ = 1'b0;
    tick(); tick();
    #1 chk("err_clean", oERROR, 0);
    kill = 4'b0100;
    tick(); tick();
    #1 chk("err_set", oERROR, 1);
    kill = '0;
    tick();
    #1 chk("err_sticky", oERROR, 1);
    inRESET = 1'b0;
    #1;
    chk("err_reset", oERROR, 0);
    chk("reset_free", oFREE_COUNT, 4);
    chk("reset_regist", oENTRY_REGIST, 0);
    #1 inRESET = 1'b1;
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
